// File: rtl/fetch_if.sv
// Fetch-stage bus between the fetch unit (master) and the ROM/decoder side (slave).
// The ROM returns the word addressed by rom_addr one clock later.
// bus carries that word to the decoder.
// A word on bus is meaningful only while bus_valid is high.
// inc is sampled at a clock edge only when bus_valid is high; when it is high, the decoder has consumed bus.
// state_dbg is 1 while the fetch FSM is in RUN and 0 while it is in PRIME.
interface fetch_if #(
  parameter int PC_WIDTH = 6,
  parameter int BW       = 24
);
  logic                inc;
  logic [BW-1:0]       rom_data;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [BW-1:0]       bus;
  logic                bus_valid;
  logic [PC_WIDTH-1:0] pc;
  logic                state_dbg;

  modport master (
    input  inc, rom_data,
    output rom_addr, bus, bus_valid, pc, state_dbg
  );

  modport slave (
    output inc, rom_data,
    input  rom_addr, bus, bus_valid, pc, state_dbg
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch in front of the decoder.
// This block also synchronises and debounces the SW8 push-switch.
module fetch_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int INST_WIDTH = 6,
  parameter int PC_WIDTH   = 6,
  parameter int PROG_DEPTH = 64,
  parameter int DB_CYCLES  = 16
) (
  input  logic     clk,
  input  logic     n_reset,
  input  logic     sw8_raw,
  output logic     SW8,
  fetch_if.master  fif
);
  localparam int BW    = INST_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(PROG_DEPTH - 1);
  localparam logic [CNT_W-1:0]    CNT_END = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                bus_valid_q, bus_valid_d;
  logic                s1_q, s2_q;
  logic                sw8_q, sw8_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // The ROM is always addressed with the next PC.
  // Its registered read therefore lines up with pc_q, with no bubble between instructions.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bus_valid_d = bus_valid_q;
    if (state_q == PRIME) begin
      state_d     = RUN;
      bus_valid_d = 1'b1;
      pc_d        = '0;
    end else begin
      bus_valid_d = 1'b1;
      if (fif.inc) pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PC_WIDTH'(1);
    end
  end

  always_comb begin
    cnt_d = '0;
    sw8_d = sw8_q;
    if (s2_q != sw8_q) begin
      if (cnt_q == CNT_END) sw8_d = s2_q;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= PRIME;
      pc_q        <= '0;
      bus_valid_q <= 1'b0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      sw8_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      bus_valid_q <= bus_valid_d;
      s1_q        <= sw8_raw;
      s2_q        <= s1_q;
      sw8_q       <= sw8_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fif.rom_addr  = pc_d;
  assign fif.bus       = fif.rom_data;
  assign fif.bus_valid = bus_valid_q;
  assign fif.pc        = pc_q;
  assign fif.state_dbg = (state_q == RUN);
  assign SW8           = sw8_q;

  if (BW != $bits(fif.rom_data)) begin : g_bw_check
    $error("fetch_unit: interface width does not match instruction format");
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// A behavioural ROM is driven by the bench.
// A reference model tracks the expected PC and the debounced SW8 level.
module tb_fetch_unit;
  localparam int PCW   = 6;
  localparam int BW    = 24;
  localparam int DEPTH = 64;
  localparam int DB    = 16;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic sw8_raw = 1'b0;
  logic sw8;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_if #(.PC_WIDTH(PCW), .BW(BW)) fif ();

  fetch_unit #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .INST_WIDTH(6),
    .PC_WIDTH(PCW), .PROG_DEPTH(DEPTH), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .n_reset(n_reset), .sw8_raw(sw8_raw), .SW8(sw8), .fif(fif)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] rom_mem [DEPTH];
  always @(posedge clk) fif.rom_data <= rom_mem[fif.rom_addr];

  // Reference model: fetch position, validity and debounced switch level
  bit   m_valid = 1'b0;
  int   m_pc    = 0;
  bit   m_sw8   = 1'b0;
  bit   raw_hist[$];

  task automatic tick();
    @(posedge clk);
    if (!n_reset) begin
      m_valid = 1'b0;
      m_pc    = 0;
      m_sw8   = 1'b0;
      raw_hist.delete();
      raw_hist.push_back(1'b0);
    end else begin
      int  n;
      bit  all_diff;
      raw_hist.push_back(sw8_raw);
      n = raw_hist.size();
      // SW8 follows once DB consecutive samples, seen two syncing edges late, all disagree with it.
      if (n >= DB + 2) begin
        all_diff = 1'b1;
        for (int k = n - DB - 2; k <= n - 3; k++)
          if (raw_hist[k] == m_sw8) all_diff = 1'b0;
        if (all_diff) m_sw8 = ~m_sw8;
      end
      if (!m_valid) m_valid = 1'b1;
      else if (fif.inc) m_pc = (m_pc + 1) % DEPTH;
    end
    if (raw_hist.size() > 40) void'(raw_hist.pop_front());
    #1;
  endtask

  task automatic do_reset(input bit inc_val);
    n_reset = 1'b0;
    fif.inc = inc_val;
    tick();
    n_reset = 1'b1;
  endtask

  task automatic fill_rom(input bit ramp);
    for (int i = 0; i < DEPTH; i++)
      rom_mem[i] = ramp ? BW'(i) : BW'($urandom);
  endtask

  task automatic test_reset();
    fill_rom(1'b0);
    n_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fif.inc = 1'($urandom);
      sw8_raw = 1'($urandom);
      tick();
    end
    n_tests++;
    if (fif.pc !== '0 || fif.bus_valid !== 1'b0 || sw8 !== 1'b0 || fif.state_dbg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: pc=%0d bus_valid=%b SW8=%b state=%b required 0/0/0/0",
               fif.pc, fif.bus_valid, sw8, fif.state_dbg);
    end
    sw8_raw = 1'b0;
  endtask

  task automatic test_sequential();
    fill_rom(1'b1);
    do_reset(1'b1);
    n_tests++;
    if (fif.bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_prime_valid: bus_valid=%b required 0", fif.bus_valid);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (fif.bus_valid !== 1'b1 || fif.bus !== BW'(i) || fif.pc !== PCW'(i)) begin
        n_fail++;
        $display("FAIL seq_word: valid=%b bus=%0d pc=%0d required 1/%0d/%0d",
                 fif.bus_valid, fif.bus, fif.pc, i, i);
      end
    end
  endtask

  task automatic test_prime_inc();
    fill_rom(1'b0);
    do_reset(1'b1);
    #1;
    n_tests++;
    if (fif.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL prime_addr: rom_addr=%0d required 0", fif.rom_addr);
    end
    tick();
    n_tests++;
    if (fif.pc !== '0 || fif.bus_valid !== 1'b1 || fif.bus !== rom_mem[0] || fif.state_dbg !== 1'b1) begin
      n_fail++;
      $display("FAIL prime_inc: pc=%0d valid=%b bus=%h required 0/1/%h",
               fif.pc, fif.bus_valid, fif.bus, rom_mem[0]);
    end
  endtask

  task automatic run_to(input int target);
    fif.inc = 1'b1;
    for (int g = 0; g < 3 * DEPTH && !(m_valid && m_pc == target); g++) tick();
    n_tests++;
    if (!(m_valid && m_pc == target)) begin
      n_fail++;
      $display("FAIL run_to: model pc=%0d never reached %0d", m_pc, target);
    end
  endtask

  task automatic test_stall();
    fill_rom(1'b0);
    do_reset(1'b0);
    run_to(7);
    fif.inc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (fif.pc !== PCW'(7) || fif.bus !== rom_mem[7] || fif.bus_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall: pc=%0d bus=%h valid=%b required 7/%h/1",
                 fif.pc, fif.bus, fif.bus_valid, rom_mem[7]);
      end
    end
    fif.inc = 1'b1;
    tick();
    n_tests++;
    if (fif.pc !== PCW'(8) || fif.bus !== rom_mem[8]) begin
      n_fail++;
      $display("FAIL stall_resume: pc=%0d bus=%h required 8/%h", fif.pc, fif.bus, rom_mem[8]);
    end
  endtask

  task automatic test_wrap();
    run_to(DEPTH - 1);
    fif.inc = 1'b1;
    #1;
    n_tests++;
    if (fif.rom_addr !== '0) begin
      n_fail++;
      $display("FAIL wrap_addr: rom_addr=%0d required 0", fif.rom_addr);
    end
    tick();
    n_tests++;
    if (fif.pc !== '0 || fif.bus !== rom_mem[0] || fif.bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: pc=%0d bus=%h valid=%b required 0/%h/1",
               fif.pc, fif.bus, fif.bus_valid, rom_mem[0]);
    end
  endtask

  task automatic test_random_fetch();
    logic [PCW-1:0] exp_addr;
    fill_rom(1'b0);
    do_reset(1'($urandom));
    for (int i = 0; i < 300; i++) begin
      fif.inc = 1'($urandom_range(0, 1));
      #1;
      exp_addr = !m_valid ? '0 : (fif.inc ? PCW'((m_pc + 1) % DEPTH) : PCW'(m_pc));
      n_tests++;
      if (fif.rom_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL rand_addr: rom_addr=%0d required %0d", fif.rom_addr, exp_addr);
      end
      tick();
      n_tests++;
      if (fif.pc !== PCW'(m_pc) || fif.bus_valid !== 1'b1 || fif.bus !== rom_mem[m_pc]) begin
        n_fail++;
        $display("FAIL rand_fetch: pc=%0d valid=%b bus=%h required %0d/1/%h",
                 fif.pc, fif.bus_valid, fif.bus, m_pc, rom_mem[m_pc]);
      end
    end
  endtask

  task automatic test_sw8_debounce();
    int lat;
    fif.inc = 1'b0;
    sw8_raw = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    sw8_raw = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (sw8 === 1'b1) lat = k;
    end
    n_tests++;
    if (lat != DB + 2) begin
      n_fail++;
      $display("FAIL sw8_latency: cycles=%0d required %0d", lat, DB + 2);
    end
    sw8_raw = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    n_tests++;
    if (sw8 !== 1'b0) begin
      n_fail++;
      $display("FAIL sw8_release: SW8=%b required 0", sw8);
    end
    sw8_raw = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    sw8_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_tests++;
      if (sw8 !== 1'b0) begin
        n_fail++;
        $display("FAIL sw8_glitch: SW8=%b required 0", sw8);
      end
    end
  endtask

  task automatic test_sw8_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        sw8_raw = 1'($urandom);
        hold = $urandom_range(1, 30);
      end
      hold--;
      fif.inc = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (sw8 !== m_sw8 || fif.pc !== PCW'(m_pc)) begin
        n_fail++;
        $display("FAIL sw8_random: SW8=%b pc=%0d required %b/%0d", sw8, fif.pc, m_sw8, m_pc);
      end
    end
  endtask

  task automatic test_reset_midrun();
    fill_rom(1'b0);
    sw8_raw = 1'b1;
    do_reset(1'b1);
    fif.inc = 1'b1;
    for (int g = 0; g < 200 && !(m_valid && m_pc == 20 && m_sw8); g++) tick();
    n_tests++;
    if (fif.pc !== PCW'(20) || sw8 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_setup: pc=%0d SW8=%b required 20/1", fif.pc, sw8);
    end
    n_reset = 1'b0;
    tick();
    n_tests++;
    if (fif.pc !== '0 || fif.bus_valid !== 1'b0 || sw8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: pc=%0d valid=%b SW8=%b required 0/0/0",
               fif.pc, fif.bus_valid, sw8);
    end
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (fif.pc !== PCW'(i) || fif.bus_valid !== 1'b1 || fif.bus !== rom_mem[i]) begin
        n_fail++;
        $display("FAIL midrun_resume: pc=%0d valid=%b bus=%h required %0d/1/%h",
                 fif.pc, fif.bus_valid, fif.bus, i, rom_mem[i]);
      end
    end
    sw8_raw = 1'b0;
  endtask

  initial begin
    fif.inc = 1'b0;
    test_reset();
    test_sequential();
    test_prime_inc();
    test_stall();
    test_wrap();
    test_random_fetch();
    test_sw8_debounce();
    test_sw8_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
